// File: rtl/mlkem_pkg.sv
// Shared ML-KEM constants and coefficient types for the polynomial datapath.
package mlkem_pkg;

    localparam int N = 256;
    localparam int Q = 3329;

    typedef logic [11:0] coeff12_t;

    localparam coeff12_t Q12 = coeff12_t'(Q);

endpackage

// File: rtl/mod_q_reduce12.sv
// Single conditional subtract of q from a 12-bit value: x mod 3329 for x < 2q.
// Combinational, zero latency.
// No handshake; pure function of its input.
module mod_q_reduce12
    import mlkem_pkg::*;
(
    input  coeff12_t x,
    output coeff12_t y
);

    // 4095 < 2q, so one subtraction always lands in 0..3328.
    assign y = (x >= Q12) ? coeff12_t'(x - Q12) : x;

endmodule

// File: rtl/byte_codec.sv
// ML-KEM ByteEncode_d / ByteDecode_d: 256 d-bit coefficients <-> 32*d LSB-first bytes.
// One clock on each path; encode and decode are independent and may run together.
// No backpressure: a new input is accepted every cycle on both paths.
module byte_codec
    import mlkem_pkg::*;
#(
    parameter int D        = 12,
    parameter int IN_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enc_valid_i,
    input  logic [N*IN_WIDTH-1:0]   f_i,
    output logic                    enc_valid_o,
    output logic [32*D*8-1:0]       b_o,
    input  logic                    dec_valid_i,
    input  logic [32*D*8-1:0]       b_i,
    output logic                    dec_valid_o,
    output logic [N*D-1:0]          f_o
);

    // 256*D stream bits == 32*D bytes; byte k bit b is stream bit 8k+b, so the
    // byte vector and the bit stream share one layout and packing is wiring.
    localparam int SW = N * D;

    logic [SW-1:0] enc_stream;
    logic [SW-1:0] dec_coeffs;

    if (D < 1 || D > 12 || IN_WIDTH < D) begin : g_bad_param
        $error("byte_codec: need 1 <= D <= 12 and IN_WIDTH >= D");
    end

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign enc_stream[i*D +: D] = f_i[i*IN_WIDTH +: D];
    end

    // Coefficient bits above D are deliberately discarded, not reduced.
    if (IN_WIDTH > D) begin : g_drop_hi
        logic unused_hi;
        assign unused_hi = ^f_i;
    end

    if (D == 12) begin : g_reduce
        for (genvar i = 0; i < N; i++) begin : g_lane
            mod_q_reduce12 u_reduce (
                .x (b_i[i*12 +: 12]),
                .y (dec_coeffs[i*12 +: 12])
            );
        end
    end else begin : g_plain
        assign dec_coeffs = b_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_valid_o <= 1'b0;
            b_o         <= '0;
            dec_valid_o <= 1'b0;
            f_o         <= '0;
        end else begin
            enc_valid_o <= enc_valid_i;
            dec_valid_o <= dec_valid_i;
            if (enc_valid_i) begin
                b_o <= enc_stream;
            end
            if (dec_valid_i) begin
                f_o <= dec_coeffs;
            end
        end
    end

endmodule

// File: tb/tb_byte_codec.sv
// Scoreboard bench: three byte_codec instances (D=1, 8, 12) checked against a byte-level model.
module tb_byte_codec;

    localparam int MAXW = 3072;
    localparam int FW   = 4096;
    localparam int NP   = 6;

    typedef struct {
        int              due;
        logic [MAXW-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic            enc_v [3];
    logic            dec_v [3];
    logic [FW-1:0]   f_in  [3];
    logic [MAXW-1:0] b_in  [3];

    logic            obs_vld [NP];
    logic [MAXW-1:0] obs_dat [NP];

    exp_t            sb [NP][$];
    logic [MAXW-1:0] last_exp [NP];
    int   cyc;
    bit   mon_en;
    int   checks;
    int   errors;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int DK = (k == 0) ? 1 : ((k == 1) ? 8 : 12);
        localparam int W  = 256 * DK;
        logic         enc_vo;
        logic         dec_vo;
        logic [W-1:0] b_o_l;
        logic [W-1:0] f_o_l;

        byte_codec #(.D(DK), .IN_WIDTH(16)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .enc_valid_i (enc_v[k]),
            .f_i         (f_in[k]),
            .enc_valid_o (enc_vo),
            .b_o         (b_o_l),
            .dec_valid_i (dec_v[k]),
            .b_i         (b_in[k][W-1:0]),
            .dec_valid_o (dec_vo),
            .f_o         (f_o_l)
        );

        assign obs_vld[2*k]   = enc_vo;
        assign obs_vld[2*k+1] = dec_vo;
        assign obs_dat[2*k]   = MAXW'(b_o_l);
        assign obs_dat[2*k+1] = MAXW'(f_o_l);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dk(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 8 : 12);
    endfunction

    function automatic string pname(input int p);
        string s;
        s = $sformatf("%s_d%0d", (p % 2 == 0) ? "enc" : "dec", dk(p / 2));
        return s;
    endfunction

    // Encode: coefficient i bit j is stream bit s=i*d+j, landing in byte s/8 bit s%8.
    function automatic logic [MAXW-1:0] ref_enc(input int d, input logic [FW-1:0] f);
        logic [7:0]      bv [384];
        logic [MAXW-1:0] r;
        int              v;
        int              s;
        r = '0;
        for (int k = 0; k < 384; k++) bv[k] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = int'(f[i*16 +: 16]) & ((1 << d) - 1);
            for (int j = 0; j < d; j++) begin
                s = i * d + j;
                if (((v >> j) & 1) == 1) bv[s / 8][s % 8] = 1'b1;
            end
        end
        for (int k = 0; k < 32 * d; k++) r[k*8 +: 8] = bv[k];
        return r;
    endfunction

    function automatic logic [MAXW-1:0] pack_coeffs(input int d, input int c [256]);
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < d; j++)
                r[i*d + j] = ((c[i] >> j) & 1) == 1;
        return r;
    endfunction

    function automatic logic [MAXW-1:0] ref_dec(input int d, input logic [MAXW-1:0] b);
        int         c [256];
        int         s;
        logic [7:0] by;
        for (int i = 0; i < 256; i++) begin
            c[i] = 0;
            for (int j = 0; j < d; j++) begin
                s  = i * d + j;
                by = b[(s / 8) * 8 +: 8];
                if (by[s % 8]) c[i] += (1 << j);
            end
            if (d == 12 && c[i] >= 3329) c[i] -= 3329;
        end
        return pack_coeffs(d, c);
    endfunction

    task automatic push(input int p, input logic [MAXW-1:0] d);
        exp_t e;
        e.due  = cyc + 1;
        e.data = d;
        sb[p].push_back(e);
    endtask

    task automatic drive_enc(input int k, input logic [FW-1:0] f);
        f_in[k]  = f;
        enc_v[k] = 1'b1;
        push(2 * k, ref_enc(dk(k), f));
    endtask

    task automatic drive_dec(input int k, input logic [MAXW-1:0] b, input logic [MAXW-1:0] e);
        b_in[k]  = b;
        dec_v[k] = 1'b1;
        push(2 * k + 1, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            enc_v[k] = 1'b0;
            dec_v[k] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic gen_rand(input int d, output logic [FW-1:0] f, output int c [256]);
        int raw;
        int v;
        f = '0;
        for (int i = 0; i < 256; i++) begin
            raw = int'($urandom);
            if (d == 12) begin
                v = int'($urandom_range(3328, 0));
                f[i*16 +: 16] = {raw[15:12], v[11:0]};
                c[i] = v;
            end else begin
                f[i*16 +: 16] = raw[15:0];
                c[i] = raw & ((1 << d) - 1);
            end
        end
    endtask

    // Monitor: each path must raise valid exactly on the due cycle and hold data otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (sb[p].size() > 0 && sb[p][0].due <= cyc) begin
                    if (!obs_vld[p] || sb[p][0].due != cyc) begin
                        errors++;
                        $display("FAIL %s valid missing at cycle %0d (due %0d)", pname(p), cyc, sb[p][0].due);
                    end
                    last_exp[p] = sb[p][0].data;
                    void'(sb[p].pop_front());
                end else if (obs_vld[p] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s spurious valid=%b at cycle %0d", pname(p), obs_vld[p], cyc);
                end
                checks++;
                if (obs_dat[p] !== last_exp[p]) begin
                    errors++;
                    for (int b = 0; b < 384; b++) begin
                        if (obs_dat[p][b*8 +: 8] !== last_exp[p][b*8 +: 8]) begin
                            $display("FAIL %s data byte %0d got %02h expected %02h at cycle %0d",
                                     pname(p), b, obs_dat[p][b*8 +: 8], last_exp[p][b*8 +: 8], cyc);
                            break;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [FW-1:0]   f;
        logic [MAXW-1:0] b;
        int              c [256];
        int              cur_c [256];
        int              prev_c [256];
        bit              have_prev;
        bit              got_new;
        logic [3071:0]   all_ones;

        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            enc_v[k] = 1'b0;
            dec_v[k] = 1'b0;
            f_in[k]  = '0;
            b_in[k]  = '0;
        end
        tick();
        tick();
        for (int p = 0; p < NP; p++) begin
            last_exp[p] = '0;
            chk({pname(p), "_reset_vld"}, 64'(obs_vld[p]), 64'd0);
            chk({pname(p), "_reset_zero"}, 64'(obs_dat[p] == '0), 64'd1);
        end
        mon_en = 1'b1;
        rst_n  = 1'b1;
        tick();

        // D=1 alternating bits -> 0xAA bytes, and back.
        for (int i = 0; i < 256; i++) f[i*16 +: 16] = 16'(i % 2);
        drive_enc(0, f);
        tick();
        chk("d1_enc_vld", 64'(obs_vld[0]), 64'd1);
        chk("d1_enc_all_aa", 64'(obs_dat[0][255:0] == {32{8'hAA}}), 64'd1);
        for (int i = 0; i < 256; i++) c[i] = i % 2;
        drive_dec(0, obs_dat[0], pack_coeffs(1, c));
        tick();
        chk("d1_dec_lane0", 64'(obs_dat[1][0]), 64'd0);
        chk("d1_dec_lane255", 64'(obs_dat[1][255]), 64'd1);

        // D=8 identity ramp and upper-bit truncation.
        for (int i = 0; i < 256; i++) f[i*16 +: 16] = 16'(i);
        drive_enc(1, f);
        tick();
        chk("d8_enc_byte200", 64'(obs_dat[2][200*8 +: 8]), 64'd200);
        chk("d8_enc_byte255", 64'(obs_dat[2][255*8 +: 8]), 64'd255);
        for (int i = 0; i < 256; i++) c[i] = i;
        drive_dec(1, obs_dat[2], pack_coeffs(8, c));
        for (int i = 0; i < 256; i++) f[i*16 +: 16] = 16'h1234;
        drive_enc(1, f);
        tick();
        chk("d8_dec_lane77", 64'(obs_dat[3][77*8 +: 8]), 64'd77);
        chk("d8_enc_all_34", 64'(obs_dat[2][2047:0] == {256{8'h34}}), 64'd1);

        // D=12 ramp, saturated decode, q boundary.
        for (int i = 0; i < 256; i++) f[i*16 +: 16] = 16'(i % 3329);
        drive_enc(2, f);
        tick();
        chk("d12_enc_bytes0_5", 64'(obs_dat[4][47:0]), 64'h0000_0030_0200_1000);
        for (int i = 0; i < 256; i++) c[i] = i;
        drive_dec(2, obs_dat[4], pack_coeffs(12, c));
        tick();
        chk("d12_dec_lane100", 64'(obs_dat[5][100*12 +: 12]), 64'd100);
        all_ones = '1;
        drive_dec(2, all_ones, ref_dec(12, all_ones));
        tick();
        chk("d12_dec_ff_lane0", 64'(obs_dat[5][11:0]), 64'd766);
        chk("d12_dec_ff_lane255", 64'(obs_dat[5][255*12 +: 12]), 64'd766);
        b = '0;
        b[11:0]  = 12'd3328;
        b[23:12] = 12'd3329;
        drive_dec(2, b, ref_dec(12, b));
        tick();
        chk("d12_dec_3328", 64'(obs_dat[5][11:0]), 64'd3328);
        chk("d12_dec_3329", 64'(obs_dat[5][23:12]), 64'd0);

        // Reset beats simultaneous valids; nothing is pushed for the dropped inputs.
        for (int k = 0; k < 3; k++) begin
            gen_rand(dk(k), f, c);
            f_in[k]  = f;
            b_in[k]  = '1;
            enc_v[k] = 1'b1;
            dec_v[k] = 1'b1;
        end
        rst_n = 1'b0;
        tick();
        for (int p = 0; p < NP; p++) begin
            last_exp[p] = '0;
            chk({pname(p), "_rst_vld"}, 64'(obs_vld[p]), 64'd0);
            chk({pname(p), "_rst_zero"}, 64'(obs_dat[p] == '0), 64'd1);
        end
        rst_n = 1'b1;

        // Random round trip, encoder output fed straight into decoder, back-to-back.
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 3; s++) begin
                void'($urandom(32'(100 * k + s + 7)));
                have_prev = 1'b0;
                for (int n = 0; n < 10; n++) begin
                    got_new = 1'b0;
                    if (n < 2 || $urandom_range(3, 0) != 0) begin
                        gen_rand(dk(k), f, cur_c);
                        drive_enc(k, f);
                        got_new = 1'b1;
                    end
                    if (have_prev) drive_dec(k, obs_dat[2*k], pack_coeffs(dk(k), prev_c));
                    tick();
                    if (got_new) begin
                        prev_c    = cur_c;
                        have_prev = 1'b1;
                    end
                end
                drive_dec(k, obs_dat[2*k], pack_coeffs(dk(k), prev_c));
                tick();
            end
            // Arbitrary byte patterns, including out-of-range 12-bit fields.
            for (int n = 0; n < 4; n++) begin
                for (int w = 0; w < MAXW / 32; w++) b[w*32 +: 32] = $urandom;
                drive_dec(k, b, ref_dec(dk(k), b));
                tick();
            end
        end

        tick();
        tick();
        for (int p = 0; p < NP; p++) chk({pname(p), "_sb_drained"}, 64'(sb[p].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
